seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_to_hex.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment
// patterns for hex digits and blank, plus the capture FSM encoding.
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;
endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup from an active-low segment pattern to a hex nibble;
// anything that is neither a digit nor all-off is flagged illegal.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_illegal
);
  always_comb begin
    nibble     = 4'h0;
    is_blank   = 1'b0;
    is_illegal = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment display bus, debounces each {an,seg} sample
// and captures the decoded value of the selected digit once it is stable.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   blank,
  output logic [N_DIGITS-1:0]   seen,
  output logic                  frame_done,
  output logic                  err,
  output logic [7:0]            err_count
);
  localparam logic [N_DIGITS-1:0] ONE    = 1;
  localparam logic [7:0]          CNT_HI = 8'(STABLE_CYCLES);

  logic [N_DIGITS-1:0]   r_an, r_prev_an;
  logic [6:0]            r_seg, r_prev_seg;
  state_t                r_state, w_state_nx;
  logic [7:0]            r_cnt, w_cnt_nx;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_blank, r_seen, w_seen_nx;
  logic                  r_fdone, r_err;
  logic [7:0]            r_err_count;

  logic [N_DIGITS-1:0] w_sel;
  logic                w_an_ok, w_same, w_cap;
  logic [3:0]          w_nib;
  logic                w_is_blank, w_is_illegal;

  seg7_to_hex u_dec (
    .seg        (r_seg),
    .nibble     (w_nib),
    .is_blank   (w_is_blank),
    .is_illegal (w_is_illegal)
  );

  // Exactly one digit enable low; all-high and multi-low both park the FSM.
  assign w_sel   = ~r_an;
  assign w_an_ok = (w_sel != '0) && ((w_sel & (w_sel - ONE)) == '0);
  assign w_same  = ({r_an, r_seg} == {r_prev_an, r_prev_seg});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap      = 1'b0;
    if (!w_an_ok) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_SETTLE;
          w_cnt_nx   = 8'd1;
        end
        ST_SETTLE: begin
          if (!w_same) begin
            w_cnt_nx = 8'd1;
          end else if (r_cnt + 8'd1 == CNT_HI) begin
            w_cap      = 1'b1;
            w_state_nx = ST_HELD;
            w_cnt_nx   = CNT_HI;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
        ST_HELD: begin
          if (!w_same) begin
            w_state_nx = ST_SETTLE;
            w_cnt_nx   = 8'd1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = 8'd0;
        end
      endcase
    end
  end

  // A completed frame clears seen, but a capture landing on the same edge wins.
  always_comb begin
    w_seen_nx = (&r_seen) ? '0 : r_seen;
    if (w_cap && !w_is_illegal) w_seen_nx = w_seen_nx | w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an        <= '1;
      r_seg       <= '1;
      r_prev_an   <= '1;
      r_prev_seg  <= '1;
      r_digits    <= '0;
      r_blank     <= '1;
      r_seen      <= '0;
      r_fdone     <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_an       <= an;
      r_seg      <= seg;
      r_prev_an  <= r_an;
      r_prev_seg <= r_seg;
      r_seen     <= w_seen_nx;
      r_fdone    <= &r_seen;
      r_err      <= w_cap && w_is_illegal;
      if (w_cap && w_is_illegal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (w_cap && w_sel[i] && !w_is_illegal) begin
          if (w_is_blank) begin
            r_blank[i] <= 1'b1;
          end else begin
            r_digits[4*i +: 4] <= w_nib;
            r_blank[i]         <= 1'b0;
          end
        end
      end
    end
  end

  assign digits     = r_digits;
  assign blank      = r_blank;
  assign seen       = r_seen;
  assign frame_done = r_fdone;
  assign err        = r_err;
  assign err_count  = r_err_count;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a decode table plus hand-written
// sequences for debounce latency, framing, error saturation and reset.
module tb_seg7_scan_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank, seen;
  logic        frame_done, err;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .blank      (blank),
    .seen       (seen),
    .frame_done (frame_done),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [6:0] seg;
    logic [3:0] nib;
    logic       blk;
    logic       er;
  } vec_t;

  vec_t       tbl[20];
  logic [6:0] scan_pat[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_blank"}, 32'(blank), 32'hF);
    check({tag, "_seen"}, 32'(seen), 32'h0);
    check({tag, "_fdone"}, 32'(frame_done), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_errcnt"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    int fd_cnt, err_pulses;
    logic fd_prev, saw5;

    tbl[0]  = '{0, 7'h40, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1, 7'h79, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{2, 7'h24, 4'h2, 1'b0, 1'b0};
    tbl[3]  = '{3, 7'h30, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{0, 7'h19, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{1, 7'h12, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{2, 7'h02, 4'h6, 1'b0, 1'b0};
    tbl[7]  = '{3, 7'h78, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{0, 7'h00, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{1, 7'h18, 4'h9, 1'b0, 1'b0};
    tbl[10] = '{2, 7'h08, 4'hA, 1'b0, 1'b0};
    tbl[11] = '{3, 7'h03, 4'hB, 1'b0, 1'b0};
    tbl[12] = '{0, 7'h46, 4'hC, 1'b0, 1'b0};
    tbl[13] = '{1, 7'h21, 4'hD, 1'b0, 1'b0};
    tbl[14] = '{2, 7'h06, 4'hE, 1'b0, 1'b0};
    tbl[15] = '{3, 7'h0E, 4'hF, 1'b0, 1'b0};
    tbl[16] = '{0, 7'h7F, 4'hC, 1'b1, 1'b0};
    tbl[17] = '{0, 7'h55, 4'hC, 1'b1, 1'b1};
    tbl[18] = '{0, 7'h40, 4'h0, 1'b0, 1'b0};
    tbl[19] = '{3, 7'h7F, 4'hF, 1'b1, 1'b0};
    scan_pat[0] = 7'h79;
    scan_pat[1] = 7'h24;
    scan_pat[2] = 7'h30;
    scan_pat[3] = 7'h19;

    // Reset values
    do_reset();
    check_reset_state("rst");

    // Single capture with exact latency
    an = 4'b1110; seg = 7'h30;
    for (int c = 0; c < 4; c++) step();
    check("lat_early_seen", 32'(seen), 32'h0);
    step();
    check("d0_val", 32'(digits[3:0]), 32'h3);
    check("d0_seen", 32'(seen), 32'h1);
    check("d0_err", 32'(err), 32'h0);
    check("d0_blank", 32'(blank), 32'hE);

    // Restart on change before stable
    do_reset();
    saw5 = 1'b0;
    an = 4'b1101; seg = 7'h12;
    for (int c = 0; c < 3; c++) begin step(); if (digits[7:4] == 4'h5) saw5 = 1'b1; end
    seg = 7'h02;
    for (int c = 0; c < 4; c++) begin step(); if (digits[7:4] == 4'h5) saw5 = 1'b1; end
    check("restart_early", 32'(seen), 32'h0);
    step();
    check("restart_d1", 32'(digits[7:4]), 32'h6);
    check("restart_no5", 32'(saw5), 32'h0);

    // Table-driven decode of every pattern
    do_reset();
    for (int k = 0; k < 20; k++) begin
      an  = ~(4'b0001 << tbl[k].slot);
      seg = tbl[k].seg;
      for (int c = 0; c < 5; c++) step();
      check($sformatf("tbl%0d_nib", k), 32'(digits[4*tbl[k].slot +: 4]), 32'(tbl[k].nib));
      check($sformatf("tbl%0d_blank", k), 32'(blank[tbl[k].slot]), 32'(tbl[k].blk));
      check($sformatf("tbl%0d_err", k), 32'(err), 32'(tbl[k].er));
      step();
    end
    check("tbl_errcnt", 32'(err_count), 32'h1);

    // Full scan produces one frame_done and clears seen
    do_reset();
    fd_cnt = 0; fd_prev = 1'b0;
    for (int d = 0; d < 5; d++) begin
      an  = ~(4'b0001 << ((d < 4) ? d : 3));
      seg = scan_pat[(d < 4) ? d : 3];
      for (int c = 0; c < 6; c++) begin
        step();
        if (fd_prev) check("fd_next_seen", 32'(seen), 32'h0);
        if (frame_done) begin
          fd_cnt++;
          check("fd_seen_clr", 32'(seen), 32'h0);
        end
        fd_prev = frame_done;
      end
    end
    check("scan_digits", 32'(digits), 32'h4321);
    check("scan_fd_cnt", 32'(fd_cnt), 32'h1);

    // Illegal pattern: single err pulse while held, then saturation
    do_reset();
    err_pulses = 0;
    an = 4'b1011; seg = 7'h55;
    for (int c = 0; c < 12; c++) begin step(); if (err) err_pulses++; end
    check("ill_pulses", 32'(err_pulses), 32'h1);
    check("ill_errcnt", 32'(err_count), 32'h1);
    check("ill_d2", 32'(digits[11:8]), 32'h0);
    check("ill_blank", 32'(blank), 32'hF);
    check("ill_seen", 32'(seen), 32'h0);
    for (int r = 0; r < 299; r++) begin
      an = 4'hF;
      step();
      an = 4'b1011;
      for (int c = 0; c < 6; c++) begin step(); if (err) err_pulses++; end
    end
    check("sat_pulses", 32'(err_pulses), 32'd300);
    check("sat_errcnt", 32'(err_count), 32'd255);

    // Multi-hot enables never capture
    do_reset();
    an = 4'b0011; seg = 7'h30;
    for (int c = 0; c < 10; c++) step();
    check_reset_state("multihot");

    // Reset mid-settle, then a full stable window after release
    do_reset();
    an = 4'b1110; seg = 7'h12;
    step(); step();
    reset = 1'b1;
    step();
    check_reset_state("midrst");
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("post_rst_early", 32'(seen), 32'h0);
    step();
    check("post_rst_d0", 32'(digits[3:0]), 32'h5);
    check("post_rst_seen", 32'(seen), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
